// File: rtl/bus_master_pkg.sv
// Shared types and sizes for the serial bus master port.
package bus_master_pkg;

    localparam int unsigned ADDR_W          = 12;
    localparam int unsigned DATA_W          = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWaitAck,
        StRdata,
        StDone
    } state_e;

endpackage

// File: rtl/serial_shifter.sv
// LSB-first shift register: parallel load, serial out at bit 0, serial in at the MSB.
module serial_shifter
    import bus_master_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_shift,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[WIDTH-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/bus_master_port.sv
// Serial bus master: shifts out a 12-bit address (plus write byte), waits for the slave
// acknowledge with a timeout, and on reads shifts in an 8-bit response.
module bus_master_port
    import bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_write_enable,
    output logic              o_read_enable,
    output logic              o_m_valid,
    output logic              o_tx_address,
    output logic              o_tx_data,
    output logic              o_m_ready,
    input  logic              i_s_ready,
    input  logic              i_s_valid,
    input  logic              i_rx_data
);

    localparam int unsigned CNT_W  = $clog2(ADDR_W);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    state_e              r_state;
    logic                r_write;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_we;
    logic                r_re;
    logic                r_m_valid;
    logic                r_m_ready;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_take;
    logic                w_ack;
    logic [DATA_W-1:0]   w_wdata_load;
    logic [ADDR_W-1:0]   w_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [DATA_W-1:0]   w_rx_q;
    logic                w_unused_bits;

    assign w_take       = (r_state == StIdle) && i_start;
    assign w_wdata_load = i_write ? i_wdata : '0;
    assign w_ack        = r_write ? i_s_ready : (r_m_ready && i_s_valid);

    // Shifting zeros in keeps both tx lines low once their payload has gone out.
    serial_shifter #(.WIDTH(ADDR_W)) u_addr_shift (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_take),
        .i_load_val (i_addr),
        .i_shift    (r_state == StAddr),
        .i_sin      (1'b0),
        .o_q        (w_addr_q)
    );

    serial_shifter #(.WIDTH(DATA_W)) u_data_shift (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_take),
        .i_load_val (w_wdata_load),
        .i_shift    (r_state == StAddr),
        .i_sin      (1'b0),
        .o_q        (w_data_q)
    );

    serial_shifter #(.WIDTH(DATA_W)) u_rx_shift (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_take),
        .i_load_val ('0),
        .i_shift    (r_state == StRdata),
        .i_sin      (i_rx_data),
        .o_q        (w_rx_q)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_write    <= 1'b0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_ready  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state   <= StAddr;
                        r_write   <= i_write;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_m_valid <= 1'b1;
                        r_we      <= i_write;
                        r_re      <= !i_write;
                    end
                end
                StAddr: begin
                    if (r_bit_cnt == CNT_W'(ADDR_W - 1)) begin
                        r_state    <= StWaitAck;
                        r_bit_cnt  <= '0;
                        r_wait_cnt <= '0;
                        r_m_valid  <= 1'b0;
                        r_m_ready  <= !r_write;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                StWaitAck: begin
                    if (w_ack) begin
                        r_m_ready <= 1'b0;
                        r_bit_cnt <= '0;
                        if (r_write) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StRdata;
                        end
                    end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        r_state   <= StIdle;
                        r_m_ready <= 1'b0;
                        r_busy    <= 1'b0;
                        r_err     <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                StRdata: begin
                    if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        // Fold in the final bit here so rdata is valid alongside done.
                        r_rdata <= {i_rx_data, w_rx_q[DATA_W-1:1]};
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= StIdle;
                    r_busy    <= 1'b0;
                    r_m_valid <= 1'b0;
                    r_m_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_rdata        = r_rdata;
    assign o_write_enable = r_we;
    assign o_read_enable  = r_re;
    assign o_m_valid      = r_m_valid;
    assign o_m_ready      = r_m_ready;
    assign o_tx_address   = w_addr_q[0];
    assign o_tx_data      = w_data_q[0];

    assign w_unused_bits = ^{w_addr_q[ADDR_W-1:1], w_data_q[DATA_W-1:1], w_rx_q[0]};

endmodule
